ibf_1_serializer: RTL and testbench

//  Inverse of the 8-point FFT first-stage butterfly. Accepts one complex frame
//  (y0..y3, re/im) per handshake and recovers the real samples x0..x3:
//  x0=(y0+y2)/2, x2=(y0-y2)/2, x1=y1_re, x3=y3_im.

---
 rtl/ibf_1_serializer.sv | 178 +++++++++++++++++
 tb/tb_ibf_1_serializer.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibf_1_serializer.sv
// ibf_1_serializer
//   Inverse of the 8-point FFT first-stage butterfly. Accepts one complex frame
//   (y0..y3, re/im) per handshake, recovers the real samples
//   x0=(y0+y2)/2, x1=y1_re, x2=(y0-y2)/2, x3=y3_im, and streams them serially
//   (x0,x1,x2,x3) on a valid/ready output port.
//
// Parameters
//   W      sample width (signed two's complement, in and out)
//   ROUND  1: (a+b+1)>>>1 round-half-up, 0: (a+b)>>>1 truncate
//
// Ports
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready   input frame handshake
//   y0_re .. y3_im        complex input frame
//   out_valid / out_ready output beat handshake
//   out_data              recovered real sample
//   out_idx               sample index 0..3 of out_data
//   out_last              high with out_idx==3
//   err                   frame consistency flag
//
// Build option
//   IBF1_CHECK_EN  when defined, err flags frames whose imaginary parts of
//                  y0/y2 are nonzero or whose y1/y3 are not conjugates.
//                  When undefined, err is constant 0.

module ibf_1_serializer #(
    parameter int W     = 16,
    parameter int ROUND = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] y0_re,
    input  logic [W-1:0] y0_im,
    input  logic [W-1:0] y1_re,
    input  logic [W-1:0] y1_im,
    input  logic [W-1:0] y2_re,
    input  logic [W-1:0] y2_im,
    input  logic [W-1:0] y3_re,
    input  logic [W-1:0] y3_im,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   out_idx,
    output logic         out_last,
    output logic         err
);

    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [W:0] RND = (ROUND != 0) ? {{W{1'b0}}, 1'b1} : '0;

    // Buffer A: computed frame waiting for the shifter
    logic [W-1:0] a_q [4];
    logic         a_full_q;

    // Shifter S and beat counter
    logic [W-1:0] s_q [4];
    logic [1:0]   cnt_q;
    state_t       state_q;

    logic         accept;
    logic         consume;
    logic         load;

    logic [W:0]   y0_ext;
    logic [W:0]   y2_ext;
    logic [W:0]   sum_p;
    logic [W:0]   sum_m;
    logic [W-1:0] x0;
    logic [W-1:0] x2;

    always_comb begin
        y0_ext = {y0_re[W-1], y0_re};
        y2_ext = {y2_re[W-1], y2_re};
        sum_p  = y0_ext + y2_ext + RND;
        sum_m  = y0_ext - y2_ext + RND;
        // Taking bits [W:1] of the W+1-bit sum is the arithmetic shift by one.
        x0     = sum_p[W:1];
        x2     = sum_m[W:1];
    end

    assign in_ready = !a_full_q;
    assign accept   = in_valid && !a_full_q;
    assign consume  = (state_q == SHIFT) && out_ready;
    // S takes A either from idle or on the last beat of the current frame,
    // which keeps back-to-back frames free of bubbles.
    assign load     = a_full_q && ((state_q == IDLE) || (consume && (cnt_q == 2'd3)));

`ifdef IBF1_CHECK_EN
    logic       a_err_q;
    logic       err_q;
    logic [W:0] y1_im_ext;
    logic [W:0] y3_im_neg;
    logic       chk;

    always_comb begin
        y1_im_ext = {y1_im[W-1], y1_im};
        y3_im_neg = '0 - {y3_im[W-1], y3_im};
        chk = (y0_im != '0) || (y2_im != '0) || (y1_re != y3_re) ||
              (y1_im_ext != y3_im_neg);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_err_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                a_err_q <= chk;
            end
            if (load) begin
                err_q <= a_err_q;
            end
        end
    end

    assign err = err_q;
`else
    logic unused_chk_inputs;
    assign unused_chk_inputs = ^{y0_im, y2_im, y3_re, y1_im};
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < 4; i++) begin
                a_q[i] <= '0;
                s_q[i] <= '0;
            end
            a_full_q <= 1'b0;
            cnt_q    <= '0;
            state_q  <= IDLE;
        end else begin
            // Accept is written after the transfer so a same-cycle accept
            // refills A while the old frame moves into S.
            if (load) begin
                a_full_q <= 1'b0;
            end
            if (accept) begin
                a_q      <= '{x0, y1_re, x2, y3_im};
                a_full_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (load) begin
                        s_q     <= a_q;
                        cnt_q   <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (consume) begin
                        if (cnt_q == 2'd3) begin
                            cnt_q <= '0;
                            if (load) begin
                                s_q <= a_q;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else begin
                            cnt_q <= cnt_q + 2'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_valid = (state_q == SHIFT);
    assign out_data  = (state_q == SHIFT) ? s_q[cnt_q] : '0;
    assign out_idx   = cnt_q;
    assign out_last  = (state_q == SHIFT) && (cnt_q == 2'd3);

endmodule

// File: tb/tb_ibf_1_serializer.sv
module tb_ibf_1_serializer;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] y0_re, y0_im, y1_re, y1_im, y2_re, y2_im, y3_re, y3_im;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   out_idx;
    logic         out_last;
    logic         err;

    logic         t_in_ready;
    logic         t_valid;
    logic [W-1:0] t_data;
    logic [1:0]   t_idx;
    logic         t_last;
    logic         t_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ibf_1_serializer #(.W(W), .ROUND(1)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .y0_re(y0_re), .y0_im(y0_im), .y1_re(y1_re), .y1_im(y1_im),
        .y2_re(y2_re), .y2_im(y2_im), .y3_re(y3_re), .y3_im(y3_im),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx), .out_last(out_last), .err(err)
    );

    ibf_1_serializer #(.W(W), .ROUND(0)) dut_trunc (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(t_in_ready),
        .y0_re(y0_re), .y0_im(y0_im), .y1_re(y1_re), .y1_im(y1_im),
        .y2_re(y2_re), .y2_im(y2_im), .y3_re(y3_re), .y3_im(y3_im),
        .out_valid(t_valid), .out_ready(out_ready),
        .out_data(t_data), .out_idx(t_idx), .out_last(t_last), .err(t_err)
    );

    // Drives a conjugate-consistent frame (optionally with y0_im set) and
    // holds in_valid until the accepting edge. Returns 1 time unit after it.
    task automatic drive_frame(input int y0r, input int y2r, input int y1r,
                               input int y3i, input int y0i);
        int neg;
        int k;
        neg   = -y3i;
        y0_re = y0r[W-1:0];
        y0_im = y0i[W-1:0];
        y1_re = y1r[W-1:0];
        y3_re = y1r[W-1:0];
        y3_im = y3i[W-1:0];
        y1_im = neg[W-1:0];
        y2_re = y2r[W-1:0];
        y2_im = '0;
        in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        {y0_re, y0_im, y1_re, y1_im, y2_re, y2_im, y3_re, y3_im} = '0;
        @(posedge clk); @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_idx !== 2'd0 ||
            out_last !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%b data=%h idx=%0d last=%b err=%b required 0,0,0,0,0",
                     out_valid, out_data, out_idx, out_last, err);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b required 1,0", in_ready, out_valid);
        end
    endtask

    task automatic test_basic;
        logic signed [W-1:0] ex [4];
        ex = '{16'sd100, 16'sd7, 16'sd20, -16'sd5};
        out_ready = 1'b1;
        drive_frame(120, 80, 7, -5, 0);
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_after_accept: out_valid=%b in_ready=%b required 0,0", out_valid, in_ready);
        end
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== ex[k] || out_idx !== 2'(k) ||
                out_last !== (k == 3)) begin
                n_fail++;
                $display("FAIL basic_beat%0d: valid=%b data=%0d idx=%0d last=%b required 1,%0d,%0d,%b",
                         k, out_valid, $signed(out_data), out_idx, out_last, ex[k], k, (k == 3));
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_idle: out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_round;
        logic signed [W-1:0] ex_r [4];
        logic signed [W-1:0] ex_t [4];
        ex_r = '{16'sd2, 16'sd0, 16'sd2, 16'sd0};
        ex_t = '{16'sd1, 16'sd0, 16'sd1, 16'sd0};
        out_ready = 1'b1;
        n_checks++;
        if (t_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL round_trunc_ready: in_ready=%b required 1", t_in_ready);
        end
        drive_frame(3, 0, 0, 0, 0);
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== ex_r[k]) begin
                n_fail++;
                $display("FAIL round_half_up_beat%0d: valid=%b data=%0d required 1,%0d",
                         k, out_valid, $signed(out_data), ex_r[k]);
            end
            n_checks++;
            if (t_valid !== 1'b1 || t_data !== ex_t[k] || t_idx !== 2'(k) ||
                t_last !== (k == 3) || t_err !== 1'b0) begin
                n_fail++;
                $display("FAIL round_trunc_beat%0d: valid=%b data=%0d idx=%0d last=%b err=%b required 1,%0d,%0d,%b,0",
                         k, t_valid, $signed(t_data), t_idx, t_last, t_err, ex_t[k], k, (k == 3));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_extremes;
        logic signed [W-1:0] ex [2][4];
        int y [2];
        ex[0] = '{-16'sd32768, -16'sd32768, 16'sd0, 16'sd32767};
        ex[1] = '{16'sd32767, 16'sd32767, 16'sd0, -16'sd32767};
        y = '{-32768, 32767};
        out_ready = 1'b1;
        for (int f = 0; f < 2; f++) begin
            drive_frame(y[f], y[f], int'(ex[f][1]), int'(ex[f][3]), 0);
            @(posedge clk); #1;
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_data !== ex[f][k] || t_data !== ex[f][k]) begin
                    n_fail++;
                    $display("FAIL extreme%0d_beat%0d: valid=%b round=%0d trunc=%0d required 1,%0d",
                             f, k, out_valid, $signed(out_data), $signed(t_data), ex[f][k]);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_back_to_back;
        logic signed [W-1:0] ex [8];
        ex = '{16'sd7, 16'sd1, 16'sd3, 16'sd2, -16'sd7, -16'sd9, -16'sd3, 16'sd100};
        out_ready = 1'b1;
        fork
            begin
                drive_frame(10, 4, 1, 2, 0);
                drive_frame(-10, -4, -9, 100, 0);
            end
            begin
                int w;
                w = 0;
                while (!out_valid && w < 20) begin
                    @(posedge clk); #1;
                    w++;
                end
                for (int k = 0; k < 8; k++) begin
                    n_checks++;
                    if (out_valid !== 1'b1 || out_data !== ex[k] || out_idx !== 2'(k % 4) ||
                        out_last !== ((k % 4) == 3)) begin
                        n_fail++;
                        $display("FAIL b2b_beat%0d: valid=%b data=%0d idx=%0d last=%b required 1,%0d,%0d,%b",
                                 k, out_valid, $signed(out_data), out_idx, out_last, ex[k], k % 4, ((k % 4) == 3));
                    end
                    @(posedge clk); #1;
                end
            end
        join
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle: out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_backpressure;
        logic signed [W-1:0] ex [8];
        ex = '{16'sd1, 16'sd55, 16'sd999, -16'sd66, 16'sd0, 16'sd3, 16'sd0, 16'sd4};
        out_ready = 1'b0;
        drive_frame(1000, -998, 55, -66, 0);
        drive_frame(-1, 0, 3, 4, 0);
        for (int c = 0; c < 10; c++) begin
            n_checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== ex[0] ||
                out_idx !== 2'd0 || out_last !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_cycle%0d: in_ready=%b valid=%b data=%0d idx=%0d last=%b required 0,1,1,0,0",
                         c, in_ready, out_valid, $signed(out_data), out_idx, out_last);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== ex[k] || out_idx !== 2'(k % 4)) begin
                n_fail++;
                $display("FAIL drain_beat%0d: valid=%b data=%0d idx=%0d required 1,%0d,%0d",
                         k, out_valid, $signed(out_data), out_idx, ex[k], k % 4);
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_idle: out_valid=%b in_ready=%b required 0,1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_midframe;
        logic signed [W-1:0] ex [4];
        ex = '{-16'sd80, 16'sd11, -16'sd20, 16'sd22};
        out_ready = 1'b0;
        drive_frame(50, 30, 5, 6, 0);
        drive_frame(70, 10, 8, 9, 0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++;
        if (out_idx !== 2'd2 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL midframe_position: idx=%0d valid=%b required 2,1", out_idx, out_valid);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_last !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset: valid=%b data=%h last=%b in_ready=%b required 0,0,0,1",
                     out_valid, out_data, out_last, in_ready);
        end
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL post_reset_quiet%0d: out_valid=%b required 0", c, out_valid);
            end
        end
        drive_frame(-100, -60, 11, 22, 0);
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== ex[k] || out_idx !== 2'(k)) begin
                n_fail++;
                $display("FAIL post_reset_beat%0d: valid=%b data=%0d idx=%0d required 1,%0d,%0d",
                         k, out_valid, $signed(out_data), out_idx, ex[k], k);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_check;
        logic signed [W-1:0] ex [4];
        logic exp_err;
`ifdef IBF1_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        ex = '{16'sd15, 16'sd1, 16'sd5, 16'sd2};
        out_ready = 1'b1;
        drive_frame(20, 10, 1, 2, 1);
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== ex[k] || err !== exp_err) begin
                n_fail++;
                $display("FAIL check_bad_beat%0d: valid=%b data=%0d err=%b required 1,%0d,%b",
                         k, out_valid, $signed(out_data), err, ex[k], exp_err);
            end
            @(posedge clk); #1;
        end
        drive_frame(20, 10, 1, 2, 0);
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== ex[k] || err !== 1'b0) begin
                n_fail++;
                $display("FAIL check_clean_beat%0d: valid=%b data=%0d err=%b required 1,%0d,0",
                         k, out_valid, $signed(out_data), err, ex[k]);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_round;
        test_extremes;
        test_back_to_back;
        test_backpressure;
        test_reset_midframe;
        test_check;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
